resampler_drain: RTL and testbench

Consumer end of the resampler output interface: on every output-rate strobe it requests one sample from every channel through `pop_o` and collects the serialized replies on `data_i`/`ack_i` into a per-channel shadow register. It publishes the complete multichannel frame when all channels have replied, or when a timeout expires. It sits between the resampler core and the downstream mixer/serializer.

---
 rtl/resampler_pkg.sv | 17 +
 rtl/drain_timeout.sv | 35 +++
 rtl/resampler_drain.sv | 149 ++++++++++++++
 tb/tb_resampler_drain.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/resampler_pkg.sv
// Shared definitions for the resampler output side.
// Sample width, drain FSM states and channel slicing helper.
package resampler_pkg;

  localparam int SAMPLE_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  function automatic int ch_lo(input int k);
    return k * SAMPLE_W;
  endfunction

endpackage

// File: rtl/drain_timeout.sv
// Loadable WAIT-cycle counter for the drain FSM.
// Clear wins over load, load wins over count; tc_o flags TC_VAL.
module drain_timeout #(
  parameter int             W      = 10,
  parameter logic [W-1:0]   TC_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      clr_i:   cnt_d = '0;
      load_i:  cnt_d = load_val_i;
      en_i:    cnt_d = cnt_q + W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/resampler_drain.sv
// Per-tick multichannel sample collector with timeout publish.
// RESAMPLER_DRAIN_HOLD_LAST_EN: missing channels hold last value.
module resampler_drain
  import resampler_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int NUM_CH_LOG2  = 3,
  parameter int TIMEOUT      = 1024,
  parameter int TIMEOUT_LOG2 = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick_i,
  output logic [NUM_CH-1:0]          pop_o,
  input  logic [SAMPLE_W-1:0]        data_i,
  input  logic [NUM_CH-1:0]          ack_i,
  output logic [NUM_CH*SAMPLE_W-1:0] frame_o,
  output logic                       frame_valid_o,
  output logic [NUM_CH-1:0]          missing_o,
  output logic                       underrun_o,
  output logic                       overrun_o,
  output logic                       busy_o
);

  localparam int FW = NUM_CH * SAMPLE_W;
  localparam logic [TIMEOUT_LOG2-1:0] TC =
    TIMEOUT_LOG2'(TIMEOUT - 1);

  if ((1 << NUM_CH_LOG2) < NUM_CH) begin : g_bad_ch_log2
    $error("NUM_CH_LOG2 too small for NUM_CH");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [FW-1:0]     shadow_q, shadow_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [NUM_CH-1:0] missing_q, missing_d;
  logic [NUM_CH-1:0] pop_q, pop_d;
  logic              fv_q, fv_d;
  logic              underrun_q, underrun_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;

  logic              in_wait;
  logic              tc;
  logic              publish;
  logic [NUM_CH-1:0] cap;
  logic [NUM_CH-1:0] miss;

  assign in_wait = (state_q == WAIT);
  assign cap     = pending_q & ack_i;
  assign miss    = pending_q & ~ack_i;
  assign publish = in_wait && ((miss == '0) || tc);

  drain_timeout #(
    .W      (TIMEOUT_LOG2),
    .TC_VAL (TC)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (state_q == ISSUE),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (in_wait),
    .tc_o       (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick_i) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (publish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    shadow_d  = shadow_q;
    if (state_q == ISSUE) pending_d = '1;
    if (in_wait) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (cap[k]) shadow_d[ch_lo(k) +: SAMPLE_W] = data_i;
      end
      pending_d = miss;
      if (publish) begin
        pending_d = '0;
`ifndef RESAMPLER_DRAIN_HOLD_LAST_EN
        // Mute concealment: absent channels publish as silence
        for (int k = 0; k < NUM_CH; k++) begin
          if (miss[k]) shadow_d[ch_lo(k) +: SAMPLE_W] = '0;
        end
`endif
      end
    end
  end

  always_comb begin
    pop_d      = {NUM_CH{state_d == ISSUE}};
    busy_d     = (state_d != IDLE);
    fv_d       = publish;
    frame_d    = publish ? shadow_d : frame_q;
    missing_d  = publish ? miss : missing_q;
    underrun_d = publish && (miss != '0);
    overrun_d  = tick_i && (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      shadow_q   <= '0;
      frame_q    <= '0;
      missing_q  <= '0;
      pop_q      <= '0;
      fv_q       <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      shadow_q   <= shadow_d;
      frame_q    <= frame_d;
      missing_q  <= missing_d;
      pop_q      <= pop_d;
      fv_q       <= fv_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  assign pop_o         = pop_q;
  assign frame_o       = frame_q;
  assign frame_valid_o = fv_q;
  assign missing_o     = missing_q;
  assign underrun_o    = underrun_q;
  assign overrun_o     = overrun_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_resampler_drain.sv
// Scoreboard bench for resampler_drain, TIMEOUT=16.
// Directed frames; monitor checks every published frame.
module tb_resampler_drain;
  import resampler_pkg::*;

  localparam int NCH = 8;
  localparam int FW  = NCH * SAMPLE_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                tick_i = 1'b0;
  logic [NCH-1:0]      pop_o;
  logic [SAMPLE_W-1:0] data_i = '0;
  logic [NCH-1:0]      ack_i = '0;
  logic [FW-1:0]       frame_o;
  logic                frame_valid_o;
  logic [NCH-1:0]      missing_o;
  logic                underrun_o;
  logic                overrun_o;
  logic                busy_o;

  resampler_drain #(
    .NUM_CH       (NCH),
    .NUM_CH_LOG2  (3),
    .TIMEOUT      (16),
    .TIMEOUT_LOG2 (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_i        (tick_i),
    .pop_o         (pop_o),
    .data_i        (data_i),
    .ack_i         (ack_i),
    .frame_o       (frame_o),
    .frame_valid_o (frame_valid_o),
    .missing_o     (missing_o),
    .underrun_o    (underrun_o),
    .overrun_o     (overrun_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0]  frame;
    logic [NCH-1:0] missing;
    logic           underrun;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_frames = 0;
  int   n_pops = 0;
  time  t_fv = 0;
  time  t_issue = 0;

  task automatic chk(input string name,
                     input logic [FW-1:0] act,
                     input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pop_o != '0) begin
      n_pops++;
      t_issue = $time;
    end
    if (underrun_o && !frame_valid_o)
      chk("underrun_alone", FW'(frame_valid_o), FW'(underrun_o));
    if (frame_valid_o) begin
      n_frames++;
      t_fv = $time;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %h required none",
                 frame_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("frame", frame_o, mon_e.frame);
        chk("missing", FW'(missing_o), FW'(mon_e.missing));
        chk("underrun", FW'(underrun_o), FW'(mon_e.underrun));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
  endtask

  task automatic ack(input int k, input logic [SAMPLE_W-1:0] d);
    ack_i    = '0;
    ack_i[k] = 1'b1;
    data_i   = d;
    cyc();
    ack_i = '0;
  endtask

  task automatic wait_frames(input int n, input string name);
    int b = 0;
    while (n_frames < n && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (n_frames < n) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d frames required %0d",
               name, n_frames, n);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [SAMPLE_W-1:0] b);
    logic [FW-1:0] f;
    for (int k = 0; k < NCH; k++)
      f[k*SAMPLE_W +: SAMPLE_W] = b + SAMPLE_W'(k);
    return f;
  endfunction

  function automatic int lat();
    return int'((t_fv - t_issue) / 10);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int f0;
    int p0;

    #3;
    chk("rst_frame", frame_o, '0);
    chk("rst_fv", FW'(frame_valid_o), '0);
    chk("rst_missing", FW'(missing_o), '0);
    chk("rst_pop", FW'(pop_o), '0);
    chk("rst_busy", FW'(busy_o), '0);
    chk("rst_over", FW'(overrun_o), '0);
    chk("rst_under", FW'(underrun_o), '0);
    #9 rst_n = 1'b1;
    cyc();
    cyc();

    // normal in-order frame
    e = '{frame: mk(24'h000100), missing: '0, underrun: 1'b0};
    exp_q.push_back(e);
    f0 = n_frames;
    do_tick();
    chk("issue_pop", FW'(pop_o), FW'(8'hFF));
    chk("issue_busy", FW'(busy_o), FW'(1));
    cyc();
    for (int k = 0; k < NCH; k++) ack(k, 24'h000100 + 24'(k));
    wait_frames(f0 + 1, "normal");
    chk("lat_normal", FW'(lat()), FW'(9));

    // out-of-order with duplicate ch3
    e = '{frame: mk(24'h000200), missing: '0, underrun: 1'b0};
    exp_q.push_back(e);
    f0 = n_frames;
    do_tick();
    cyc();
    ack(7, 24'h000207);
    ack(3, 24'h000203);
    ack(3, 24'hFFFFFF);
    ack(0, 24'h000200);
    ack(1, 24'h000201);
    ack(2, 24'h000202);
    ack(4, 24'h000204);
    ack(5, 24'h000205);
    ack(6, 24'h000206);
    wait_frames(f0 + 1, "ooo");
    chk("lat_ooo", FW'(lat()), FW'(10));

    // timeout with ch5 silent
    e.frame = mk(24'h000300);
`ifdef RESAMPLER_DRAIN_HOLD_LAST_EN
    e.frame[5*SAMPLE_W +: SAMPLE_W] = 24'h000205;
`else
    e.frame[5*SAMPLE_W +: SAMPLE_W] = 24'h000000;
`endif
    e.missing  = 8'h20;
    e.underrun = 1'b1;
    exp_q.push_back(e);
    f0 = n_frames;
    do_tick();
    cyc();
    for (int k = 0; k < NCH; k++)
      if (k != 5) ack(k, 24'h000300 + 24'(k));
    wait_frames(f0 + 1, "timeout");
    chk("lat_timeout", FW'(lat()), FW'(17));
    chk("missing_held", FW'(missing_o), FW'(8'h20));

    // ch5 acks on the terminal-count cycle
    e = '{frame: mk(24'h000400), missing: '0, underrun: 1'b0};
    exp_q.push_back(e);
    f0 = n_frames;
    do_tick();
    cyc();
    for (int k = 0; k < NCH; k++)
      if (k != 5) ack(k, 24'h000400 + 24'(k));
    repeat (8) cyc();
    ack(5, 24'h000405);
    wait_frames(f0 + 1, "tc_edge");
    chk("lat_tc_edge", FW'(lat()), FW'(17));

    // overrun: second tick two cycles after the first
    e = '{frame: mk(24'h000500), missing: '0, underrun: 1'b0};
    exp_q.push_back(e);
    f0 = n_frames;
    p0 = n_pops;
    do_tick();
    cyc();
    chk("no_overrun_yet", FW'(overrun_o), '0);
    do_tick();
    chk("overrun_pulse", FW'(overrun_o), FW'(1));
    for (int k = 0; k < NCH; k++) ack(k, 24'h000500 + 24'(k));
    wait_frames(f0 + 1, "overrun");
    repeat (3) cyc();
    chk("one_issue", FW'(n_pops - p0), FW'(1));
    chk("one_frame", FW'(n_frames - f0), FW'(1));
    chk("overrun_cleared", FW'(overrun_o), '0);

    // async reset mid-WAIT, late acks ignored
    f0 = n_frames;
    do_tick();
    cyc();
    ack(0, 24'h000600);
    ack(1, 24'h000601);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_frame", frame_o, '0);
    chk("arst_missing", FW'(missing_o), '0);
    chk("arst_busy", FW'(busy_o), '0);
    chk("arst_pop", FW'(pop_o), '0);
    cyc();
    rst_n = 1'b1;
    for (int k = 2; k < NCH; k++) ack(k, 24'h000600 + 24'(k));
    repeat (20) cyc();
    chk("no_frame_after_rst", FW'(n_frames), FW'(f0));
    chk("idle_after_rst", FW'(busy_o), '0);
    chk("frame_after_rst", frame_o, '0);

    e = '{frame: mk(24'h000700), missing: '0, underrun: 1'b0};
    exp_q.push_back(e);
    do_tick();
    cyc();
    for (int k = 0; k < NCH; k++) ack(k, 24'h000700 + 24'(k));
    wait_frames(f0 + 1, "post_rst");
    chk("lat_post_rst", FW'(lat()), FW'(9));
    repeat (3) cyc();
    chk("sb_empty", FW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
